// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: write-back select encoding, the control
// payload carried alongside each beat, and its idle/bubble value.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC4  = 2'd3
    } wb_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_write;
        wb_sel_e wb_sel;
    } stage_ctrl_t;

    localparam int PSR_CTRL_W = $bits(stage_ctrl_t);

    // A bubble must never write anything back.
    localparam stage_ctrl_t CTRL_NOP = '{reg_write: 1'b0, mem_write: 1'b0, wb_sel: WB_NONE};
    localparam logic [PSR_CTRL_W-1:0] PSR_CTRL_RST = CTRL_NOP;

    function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
        return {1'b0, main_valid} + {1'b0, skid_valid};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// Two-entry skid buffer: head ("main") entry drives the output, the skid entry
// catches the one beat that can arrive while in_ready is registered low-late.
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = PSR_CTRL_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid_reg, main_valid_next;
    logic [DATA_W-1:0] main_data_reg,  main_data_next;
    logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
    logic              in_ready_reg,   in_ready_next;
    logic              push;
    logic              pop;

    assign push = in_valid && in_ready_reg;
    assign pop  = main_valid_reg && out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        main_ctrl_next  = main_ctrl_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_ctrl_next  = skid_ctrl_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (pop && skid_valid_reg) begin
            // in_ready is low while the skid entry is full, so no push here
            main_data_next  = skid_data_reg;
            main_ctrl_next  = skid_ctrl_reg;
            skid_valid_next = 1'b0;
        end else if (pop) begin
            main_valid_next = push;
            if (push) begin
                main_data_next = in_data;
                main_ctrl_next = in_ctrl;
            end
        end else if (push) begin
            if (!main_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = in_data;
                main_ctrl_next  = in_ctrl;
            end else begin
                skid_valid_next = 1'b1;
                skid_data_next  = in_data;
                skid_ctrl_next  = in_ctrl;
            end
        end
        // Skid is only ever full alongside main, so "room left" is just !skid.
        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_ctrl_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_ctrl_reg  <= '0;
            in_ready_reg   <= 1'b1;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            main_ctrl_reg  <= main_ctrl_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_ctrl_reg  <= skid_ctrl_next;
            in_ready_reg   <= in_ready_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;
    assign out_ctrl  = main_ctrl_reg;
    assign occupancy = occ_count(main_valid_reg, skid_valid_reg);

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, optional skid buffer and a
// saturating downstream-bubble counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = PSR_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(PSR_CTRL_RST),
    parameter int                SKID     = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [15:0]       bubble_cnt
);

    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic [15:0]       bubble_reg;

    if (SKID == 1) begin : g_skid
        pipe_skid_buf #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_skid (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_ctrl   (in_ctrl),
            .out_valid (head_valid),
            .out_ready (out_ready),
            .out_data  (head_data),
            .out_ctrl  (head_ctrl),
            .occupancy (occupancy)
        );
    end else begin : g_single
        logic              valid_reg;
        logic [DATA_W-1:0] data_reg;
        logic [CTRL_W-1:0] ctrl_reg;
        logic              accept;

        assign in_ready = !valid_reg || out_ready;
        assign accept   = in_valid && in_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
                ctrl_reg  <= CTRL_RST;
            end else if (flush) begin
                valid_reg <= 1'b0;
            end else if (accept) begin
                valid_reg <= 1'b1;
                data_reg  <= in_data;
                ctrl_reg  <= in_ctrl;
            end else if (out_ready) begin
                valid_reg <= 1'b0;
            end
        end

        assign head_valid = valid_reg;
        assign head_data  = data_reg;
        assign head_ctrl  = ctrl_reg;
        assign occupancy  = {1'b0, valid_reg};
    end

    // Bubbles survive flush: they measure downstream starvation over the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_reg <= '0;
        end else if (!head_valid && out_ready && bubble_reg != 16'hFFFF) begin
            bubble_reg <= bubble_reg + 16'd1;
        end
    end

    assign out_valid  = head_valid;
    assign out_data   = head_data;
    assign out_ctrl   = head_valid ? head_ctrl : CTRL_RST;
    assign bubble_cnt = bubble_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=0 and a SKID=1 stage with the same stimulus and scoreboards
// each against a plain FIFO-of-accepted-beats model.
module tb_pipe_stage_reg;

    typedef logic [35:0] beat_t;
    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } dchk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ctrl;
    logic        out_ready;
    logic        flush;

    logic        in_ready_w  [2];
    logic        out_valid_w [2];
    logic [31:0] out_data_w  [2];
    logic [3:0]  out_ctrl_w  [2];
    logic [1:0]  occ_w       [2];
    logic [15:0] bub_w       [2];

    beat_t       exp_q [2][$];
    dchk_t       dir_q [$];
    int          bub_model [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        pipe_stage_reg #(
            .DATA_W (32),
            .CTRL_W (4),
            .SKID   (gi)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready_w[gi]),
            .in_data    (in_data),
            .in_ctrl    (in_ctrl),
            .out_valid  (out_valid_w[gi]),
            .out_ready  (out_ready),
            .out_data   (out_data_w[gi]),
            .out_ctrl   (out_ctrl_w[gi]),
            .flush      (flush),
            .occupancy  (occ_w[gi]),
            .bubble_cnt (bub_w[gi])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dir_q.push_back(d);
    endtask

    // Monitor: sole owner of the counters; checks the state left by the last edge,
    // then advances the model for the coming edge.
    always @(negedge clk) begin
        int    sz;
        beat_t head;
        for (int k = 0; k < 2; k++) begin
            sz = exp_q[k].size();
            chk($sformatf("occupancy%0d", k), 64'(occ_w[k]), 64'(sz));
            chk($sformatf("out_valid%0d", k), 64'(out_valid_w[k]), 64'(sz != 0));
            if (sz == 0) begin
                chk($sformatf("idle_ctrl%0d", k), 64'(out_ctrl_w[k]), 64'h0);
            end else begin
                head = exp_q[k][0];
                chk($sformatf("head%0d", k), 64'({out_ctrl_w[k], out_data_w[k]}), 64'(head));
            end
            if (k == 0) chk("in_ready0", 64'(in_ready_w[0]), 64'(sz == 0 || out_ready));
            else        chk("in_ready1", 64'(in_ready_w[1]), 64'(sz < 2));
            chk($sformatf("bubble%0d", k), 64'(bub_w[k]), 64'(bub_model[k]));

            if (rst) begin
                exp_q[k].delete();
                bub_model[k] = 0;
            end else begin
                if (sz == 0 && out_ready && bub_model[k] < 65535) bub_model[k]++;
                if (flush) begin
                    exp_q[k].delete();
                end else if (sz != 0 && out_ready) begin
                    head = exp_q[k].pop_front();
                    chk($sformatf("deliver%0d", k), 64'({out_ctrl_w[k], out_data_w[k]}), 64'(head));
                    $display("beat dut%0d data=%08h ctrl=%1h", k, out_data_w[k], out_ctrl_w[k]);
                end
            end
        end
        while (dir_q.size() != 0) begin
            dchk_t d;
            d = dir_q.pop_front();
            chk(d.name, d.act, d.exp);
        end
    end

    // One cycle of stimulus; expected beats are queued when a handshake is seen.
    task automatic drive(input logic iv, input logic [31:0] d, input logic [3:0] c,
                         input logic ordy, input logic fl, input logic r);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            if (iv && in_ready_w[k] && !r && !fl) exp_q[k].push_back({c, d});
        @(posedge clk);
        #1;
    endtask

    initial begin
        bub_model[0] = 0;
        bub_model[1] = 0;
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_ctrl = 4'hF;
        out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;

        // Reset with a beat on the input
        drive(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            expect_eq($sformatf("rst_valid%0d", k), 64'(out_valid_w[k]), 64'h0);
            expect_eq($sformatf("rst_ctrl%0d", k),  64'(out_ctrl_w[k]),  64'h0);
            expect_eq($sformatf("rst_bub%0d", k),   64'(bub_w[k]),       64'h0);
            expect_eq($sformatf("rst_rdy%0d", k),   64'(in_ready_w[k]),  64'h1);
            expect_eq($sformatf("rst_data%0d", k),  64'(out_data_w[k]),  64'h0);
        end

        // Streaming 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 4'(i), 1'b1, 1'b0, 1'b0);
            expect_eq($sformatf("stream_data%0d", i), 64'(out_data_w[0]), 64'(i));
            expect_eq($sformatf("stream_occ%0d", i),  64'(occ_w[0]),       64'h1);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure into the skid buffer
        drive(1'b1, 32'hA, 4'h1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 4'h2, 1'b0, 1'b0, 1'b0);
        expect_eq("bp_occ_full", 64'(occ_w[1]), 64'h2);
        expect_eq("bp_rdy_full", 64'(in_ready_w[1]), 64'h0);
        drive(1'b1, 32'hC, 4'h3, 1'b0, 1'b0, 1'b0);
        expect_eq("bp_occ_hold", 64'(occ_w[1]), 64'h2);
        expect_eq("bp_head_a",   64'(out_data_w[1]), 64'hA);
        drive(1'b1, 32'hC, 4'h3, 1'b1, 1'b0, 1'b0);
        expect_eq("bp_head_b",   64'(out_data_w[1]), 64'hB);
        expect_eq("bp_rdy_back", 64'(in_ready_w[1]), 64'h1);
        drive(1'b1, 32'hC, 4'h3, 1'b1, 1'b0, 1'b0);
        expect_eq("bp_head_c",   64'(out_data_w[1]), 64'hC);
        expect_eq("bp_occ_c",    64'(occ_w[1]), 64'h1);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        expect_eq("bp_drained",  64'(occ_w[1]), 64'h0);

        // Flush colliding with handshakes on both sides at occupancy 2
        drive(1'b1, 32'h11, 4'h4, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 4'h5, 1'b0, 1'b0, 1'b0);
        expect_eq("fl_occ_pre", 64'(occ_w[1]), 64'h2);
        drive(1'b1, 32'h55, 4'h6, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            expect_eq($sformatf("fl_valid%0d", k), 64'(out_valid_w[k]), 64'h0);
            expect_eq($sformatf("fl_occ%0d", k),   64'(occ_w[k]),       64'h0);
            expect_eq($sformatf("fl_ctrl%0d", k),  64'(out_ctrl_w[k]),  64'h0);
        end
        expect_eq("fl_rdy1", 64'(in_ready_w[1]), 64'h1);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        expect_eq("fl_no55", 64'(out_valid_w[1]), 64'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 9) < 7), $urandom, 4'($urandom),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 199) == 0));
        end

        // Bubble counter saturation, then flush must not clear it
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++) drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        expect_eq("sat_bub0", 64'(bub_w[0]), 64'hFFFF);
        expect_eq("sat_bub1", 64'(bub_w[1]), 64'hFFFF);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        expect_eq("sat_flush0", 64'(bub_w[0]), 64'hFFFF);
        expect_eq("sat_flush1", 64'(bub_w[1]), 64'hFFFF);
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the data payload (pc_plus4, alu_result, rd_data and instruction concatenated by the caller).
REQ-002 SHALL have parameter CTRL_W, default 4, width of the control payload (RegWrite, WBSel and similar).
REQ-003 SHALL have parameter CTRL_RST, default all-zero, control value driven on reset and on any bubble (e.g. RegWrite=0, WBSel=WB_NONE).
REQ-004 SHALL have parameter SKID, default 0; 0 = single register, 1 = two-entry skid buffer with registered in_ready.
REQ-005 SHALL provide ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  head data payload.
- out_ctrl  out  CTRL_W  head control payload, or CTRL_RST when out_valid=0.
- flush  in  1  kill all held beats.
- occupancy  out  2  beats held (0..1 when SKID=0, 0..2 when SKID=1).
- bubble_cnt  out  16  saturating count of downstream bubble cycles.

Function
REQ-006 Transfers SHALL occur only on handshakes: in on in_valid&in_ready, out on out_valid&out_ready.
REQ-007 Latency SHALL be 1 cycle: a beat accepted at edge N is presented on out_* after edge N.
REQ-008 SKID=0: in_ready SHALL equal !out_valid | out_ready (combinational). Simultaneous in/out handshake on a full register SHALL replace the contents; occupancy stays 1.
REQ-009 SKID=1: in_ready SHALL be registered and equal (occupancy<2). Ordering SHALL be strict FIFO: main entry is the head; the skid entry is promoted to head on the edge the head is consumed.
REQ-010 SKID=1, occupancy=2: in_ready SHALL be 0; no beat is lost or duplicated.
REQ-011 SKID=1, simultaneous in and out handshake at occupancy 1: occupancy SHALL stay 1 and the new beat SHALL become head.
REQ-012 While out_valid=0, out_ctrl SHALL equal CTRL_RST; out_data SHALL hold its last value (don't-care).
REQ-013 flush=1 at edge N SHALL leave occupancy=0 and out_valid=0 after edge N. Any beat handshaken at edge N on either side SHALL be discarded. flush SHALL dominate all other inputs.
REQ-014 SKID=1: after flush, in_ready SHALL be 1 on the next cycle.
REQ-015 bubble_cnt SHALL increment on each edge where out_valid=0 and out_ready=1. It SHALL hold at 16'hFFFF and SHALL NOT be cleared by flush.
REQ-016 out_valid SHALL NOT depend combinationally on out_ready. out_data and out_ctrl SHALL remain stable while out_valid&!out_ready.

Reset
REQ-017 On rst=1 at an edge, the stage SHALL set occupancy=0, out_valid=0, out_ctrl=CTRL_RST, out_data=0 and bubble_cnt=0.
REQ-018 in_ready SHALL be 1 after reset in both SKID modes.
REQ-019 rst SHALL dominate flush and all handshakes. Reset mid-transfer SHALL discard every held beat.

Structure
REQ-020 CTRL_W/CTRL_RST helper constants and the wb_sel_e-based control struct width SHALL live in the shared defines package.
REQ-021 The skid buffer SHALL be one sub-module, pipe_skid_buf, instantiated only under a generate on SKID=1. The bubble counter SHALL stay inline.

Verification
REQ-022 Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> after release out_valid=0, out_ctrl=CTRL_RST, bubble_cnt=0, in_ready=1.
REQ-023 Streaming, SKID=0: out_ready=1, beats 1..8 on consecutive cycles -> out_data 1..8 one cycle later each, no gaps, occupancy=1 throughout.
REQ-024 Backpressure, SKID=1: out_ready=0, push 0xA, 0xB, 0xC -> 0xA and 0xB accepted, in_ready=0 with occupancy=2, 0xC held upstream. Then out_ready=1 -> order A, B, C delivered.
REQ-025 Flush collision: occupancy=2, flush=1 together with in_valid=1 (0x55) and out_ready=1 -> next cycle out_valid=0, occupancy=0, 0x55 never appears, out_ctrl=CTRL_RST.
REQ-026 Bubble saturation: in_valid=0, out_ready=1 for 70000 cycles -> bubble_cnt=16'hFFFF and stays there; unchanged by a later flush.
REQ-027 Random valid/ready with SKID in {0,1} against a reference queue -> every accepted beat is delivered exactly once, in order, ctrl intact.
